// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared definitions for the multicycle controller: state codes, datapath select
// codes, opcode classes and the packed control word driven by the output decoder.
package multicycle_ctrl_fsm_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_UNKNOWN  = 4'd10
    } state_t;

    // ALUSrcA selects
    localparam logic [1:0] SRCA_RD1    = 2'b00;
    localparam logic [1:0] SRCA_PC     = 2'b01;
    localparam logic [1:0] SRCA_ALURES = 2'b10;

    // ALUSrcB selects
    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_EXTIMM = 2'b01;
    localparam logic [1:0] SRCB_FOUR   = 2'b10;

    // ResultSrc selects
    localparam logic [1:0] RES_ALUOUT  = 2'b00;
    localparam logic [1:0] RES_DATA    = 2'b01;
    localparam logic [1:0] RES_ALURES  = 2'b10;

    // Op field classes
    localparam logic [1:0] OP_DP    = 2'b00;
    localparam logic [1:0] OP_MEM   = 2'b01;
    localparam logic [1:0] OP_B     = 2'b10;
    localparam logic [1:0] OP_UNDEF = 2'b11;

    typedef struct packed {
        logic       ir_write;
        logic       next_pc;
        logic       reg_w;
        logic       mem_w;
        logic       branch;
        logic       adr_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic       alu_op;
        logic       illegal;
    } ctrl_word_t;

    // States whose exit completes (retires) an instruction.
    function automatic logic is_retire_state(input state_t s);
        return (s == S_MEMWB) || (s == S_MEMWR) || (s == S_ALUWB) || (s == S_BRANCH);
    endfunction

    // States that perform a memory access and may be stretched by a wait.
    function automatic logic is_mem_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_ctrl_out_decode.sv
// Combinational Moore decode: state (plus memory ready) to the datapath control word.
// Ready only masks the one-shot fetch and store strobes; the caller ties it high when waits are off.
import multicycle_ctrl_fsm_pkg::*;

module ctrl_out_decode (
    input  state_t     state,
    input  logic       ready,
    output ctrl_word_t ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.ir_write   = ready;
                ctrl.next_pc    = ready;
                ctrl.adr_src    = 1'b0;
                ctrl.alu_src_a  = SRCA_PC;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.result_src = RES_ALURES;
                ctrl.alu_op     = 1'b0;
            end
            S_DECODE: begin
                ctrl.alu_src_a  = SRCA_PC;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.result_src = RES_ALURES;
            end
            S_MEMADR: begin
                ctrl.alu_src_a  = SRCA_RD1;
                ctrl.alu_src_b  = SRCB_EXTIMM;
                ctrl.alu_op     = 1'b0;
            end
            S_MEMRD: begin
                ctrl.adr_src    = 1'b1;
                ctrl.result_src = RES_ALUOUT;
            end
            S_MEMWB: begin
                ctrl.result_src = RES_DATA;
                ctrl.reg_w      = 1'b1;
            end
            S_MEMWR: begin
                ctrl.adr_src    = 1'b1;
                ctrl.result_src = RES_ALUOUT;
                ctrl.mem_w      = ready;
            end
            S_EXECUTER: begin
                ctrl.alu_src_a  = SRCA_RD1;
                ctrl.alu_src_b  = SRCB_REG;
                ctrl.alu_op     = 1'b1;
            end
            S_EXECUTEI: begin
                ctrl.alu_src_a  = SRCA_RD1;
                ctrl.alu_src_b  = SRCB_EXTIMM;
                ctrl.alu_op     = 1'b1;
            end
            S_ALUWB: begin
                ctrl.result_src = RES_ALUOUT;
                ctrl.reg_w      = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a  = SRCA_ALURES;
                ctrl.alu_src_b  = SRCB_EXTIMM;
                ctrl.result_src = RES_ALURES;
                ctrl.branch     = 1'b1;
                ctrl.alu_op     = 1'b0;
            end
            S_UNKNOWN: begin
                ctrl.illegal    = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle ARM main controller: state register, next-state logic and retired-instruction counter.
// Optional memory wait handshake enabled by defining CTRL_MEM_WAIT_EN.
import multicycle_ctrl_fsm_pkg::*;

module multicycle_ctrl_fsm #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       Op,
    input  logic [5:0]       Funct,
`ifdef CTRL_MEM_WAIT_EN
    input  logic             mem_ready,
`endif
    output logic             IRWrite,
    output logic             NextPC,
    output logic             RegW,
    output logic             MemW,
    output logic             Branch,
    output logic             AdrSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ResultSrc,
    output logic             ALUOp,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);

    state_t           state_q;
    state_t           state_d;
    logic             ready;
    logic             advance;
    logic [CNT_W-1:0] count_q;
    ctrl_word_t       ctrl;
    logic             unused_funct;

`ifdef CTRL_MEM_WAIT_EN
    assign ready = mem_ready;
`else
    assign ready = 1'b1;
`endif

    // Only the I and L/S bits steer sequencing; the rest belong to the ALU decoder.
    assign unused_funct = ^Funct[4:1];

    // Memory-access states leave only on an edge where the access completes.
    assign advance = is_mem_state(state_q) ? ready : 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            if (is_retire_state(state_q) && advance)
                count_q <= count_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    state_d = ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (Op)
                    OP_DP:   state_d = Funct[5] ? S_EXECUTEI : S_EXECUTER;
                    OP_MEM:  state_d = S_MEMADR;
                    OP_B:    state_d = S_BRANCH;
                    default: state_d = S_UNKNOWN;
                endcase
            end
            S_MEMADR:   state_d = Funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:    state_d = ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:    state_d = ready ? S_FETCH : S_MEMWR;
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            S_MEMWB:    state_d = S_FETCH;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_UNKNOWN:  state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    ctrl_out_decode u_decode (
        .state (state_q),
        .ready (ready),
        .ctrl  (ctrl)
    );

    assign IRWrite     = ctrl.ir_write;
    assign NextPC      = ctrl.next_pc;
    assign RegW        = ctrl.reg_w;
    assign MemW        = ctrl.mem_w;
    assign Branch      = ctrl.branch;
    assign AdrSrc      = ctrl.adr_src;
    assign ALUSrcA     = ctrl.alu_src_a;
    assign ALUSrcB     = ctrl.alu_src_b;
    assign ResultSrc   = ctrl.result_src;
    assign ALUOp       = ctrl.alu_op;
    assign illegal     = ctrl.illegal;
    assign instr_count = count_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Scoreboard bench for multicycle_ctrl_fsm: a per-instruction phase model predicts every
// cycle's control word and counter; a negedge monitor pops and compares.
module tb_multicycle_ctrl_fsm;

    localparam int W = 46;

    localparam int P_FETCH = 0, P_DECODE = 1, P_MEMADR = 2, P_MEMRD = 3, P_MEMWB = 4,
                   P_MEMWR = 5, P_EXR = 6, P_EXI = 7, P_ALUWB = 8, P_BRANCH = 9, P_UNK = 10;

`ifdef CTRL_MEM_WAIT_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic        mem_ready;
    logic        ir_write, next_pc, reg_w, mem_w, branch, adr_src, alu_op, illegal;
    logic [1:0]  alu_src_a, alu_src_b, result_src;
    logic [31:0] instr_count;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] act;
    logic [31:0]  model_cnt;
    int           checks = 0;
    int           errors = 0;
    int           cycle_no = 0;

    always #5 clk = ~clk;

    multicycle_ctrl_fsm #(.CNT_W(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .Op          (op),
        .Funct       (funct),
`ifdef CTRL_MEM_WAIT_EN
        .mem_ready   (mem_ready),
`endif
        .IRWrite     (ir_write),
        .NextPC      (next_pc),
        .RegW        (reg_w),
        .MemW        (mem_w),
        .Branch      (branch),
        .AdrSrc      (adr_src),
        .ALUSrcA     (alu_src_a),
        .ALUSrcB     (alu_src_b),
        .ResultSrc   (result_src),
        .ALUOp       (alu_op),
        .illegal     (illegal),
        .instr_count (instr_count)
    );

    assign act = {ir_write, next_pc, reg_w, mem_w, branch, adr_src, alu_src_a, alu_src_b,
                  result_src, alu_op, illegal, instr_count};

    // Expected outputs of one instruction phase, straight from the phase/output table.
    function automatic logic [W-1:0] phase_word(input int ph, input logic rdy, input logic [31:0] cnt);
        logic ir, np, rw, mw, br, as, ao, il;
        logic [1:0] sa, sb, rs;
        ir = 0; np = 0; rw = 0; mw = 0; br = 0; as = 0; ao = 0; il = 0;
        sa = 2'b00; sb = 2'b00; rs = 2'b00;
        case (ph)
            P_FETCH:  begin ir = rdy; np = rdy; sa = 2'b01; sb = 2'b10; rs = 2'b10; end
            P_DECODE: begin sa = 2'b01; sb = 2'b10; rs = 2'b10; end
            P_MEMADR: begin sb = 2'b01; end
            P_MEMRD:  begin as = 1; end
            P_MEMWB:  begin rs = 2'b01; rw = 1; end
            P_MEMWR:  begin as = 1; mw = rdy; end
            P_EXR:    begin ao = 1; end
            P_EXI:    begin sb = 2'b01; ao = 1; end
            P_ALUWB:  begin rw = 1; end
            P_BRANCH: begin sa = 2'b10; sb = 2'b01; rs = 2'b10; br = 1; end
            P_UNK:    begin il = 1; end
            default:  ;
        endcase
        return {ir, np, rw, mw, br, as, sa, sb, rs, ao, il, cnt};
    endfunction

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got ctrl=%b count=%0d, expected ctrl=%b count=%0d",
                     name, cycle_no, got[W-1:32], got[31:0], exp[W-1:32], exp[31:0]);
        end
    endtask

    always @(posedge clk) cycle_no++;

    always @(negedge clk) begin
        if (exp_q.size() > 0) check("scoreboard", act, exp_q.pop_front());
    end

    // Issue one instruction: predict its phase sequence, push every cycle's word, then
    // drive mem_ready per cycle. With abort set, stop while sitting in the 4th phase.
    task automatic run_instr(input logic [1:0] o, input logic [5:0] f, input int fetch_stall,
                             input bit abort);
        int   ph[$];
        logic rdy_q[$];
        int   stalls;
        int   ncyc;
        ph.push_back(P_FETCH);
        ph.push_back(P_DECODE);
        case (o)
            2'b00: begin ph.push_back(f[5] ? P_EXI : P_EXR); ph.push_back(P_ALUWB); end
            2'b01: begin
                ph.push_back(P_MEMADR);
                if (f[0]) begin ph.push_back(P_MEMRD); ph.push_back(P_MEMWB); end
                else ph.push_back(P_MEMWR);
            end
            2'b10: ph.push_back(P_BRANCH);
            default: ph.push_back(P_UNK);
        endcase
        if (abort) while (ph.size() > 4) void'(ph.pop_back());
        foreach (ph[i]) begin
            stalls = 0;
            if (WAIT_EN && !abort && (ph[i] == P_FETCH || ph[i] == P_MEMRD || ph[i] == P_MEMWR))
                stalls = (ph[i] == P_FETCH && fetch_stall >= 0) ? fetch_stall : $urandom_range(0, 3);
            for (int s = 0; s < stalls; s++) begin
                exp_q.push_back(phase_word(ph[i], 1'b0, model_cnt));
                rdy_q.push_back(1'b0);
            end
            exp_q.push_back(phase_word(ph[i], 1'b1, model_cnt));
            rdy_q.push_back(1'b1);
        end
        op    = o;
        funct = f;
        ncyc  = abort ? rdy_q.size() - 1 : rdy_q.size();
        mem_ready = rdy_q[0];
        for (int c = 0; c < ncyc; c++) begin
            mem_ready = rdy_q[c];
            @(posedge clk);
            #1;
        end
        if (!abort && o != 2'b11) model_cnt = model_cnt + 32'd1;
    endtask

    initial begin
        reset     = 1'b1;
        op        = 2'b00;
        funct     = 6'd0;
        mem_ready = 1'b1;
        model_cnt = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_fetch", act, phase_word(P_FETCH, 1'b1, 32'd0));
        @(negedge clk);
        check("reset_hold", act, phase_word(P_FETCH, 1'b1, 32'd0));
        @(posedge clk);
        #1;
        reset = 1'b0;

        run_instr(2'b00, 6'b000100, 3, 1'b0);  // ADD reg, fetch held 3 cycles when waits exist
        run_instr(2'b01, 6'b011001, -1, 1'b0); // LDR
        run_instr(2'b01, 6'b011000, -1, 1'b0); // STR
        run_instr(2'b10, 6'b101010, -1, 1'b0); // B
        run_instr(2'b11, 6'b000000, -1, 1'b0); // undefined
        run_instr(2'b00, 6'b100100, -1, 1'b0); // ADD imm

        // Reset while sitting in MEMRD: next cycle is FETCH with counter cleared.
        run_instr(2'b01, 6'b011001, -1, 1'b1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_cnt = 32'd0;

        for (int n = 0; n < 200; n++)
            run_instr(2'($urandom_range(0, 3)), 6'($urandom_range(0, 63)), -1, 1'b0);

        repeat (3) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected words left, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
Main sequencing FSM of the multicycle ARM controller. It decodes Op/Funct, steps each instruction through fetch, decode, execute, memory and writeback states, and drives the datapath mux selects. It also produces the unconditioned NextPC/RegW/MemW/Branch strobes that the condition-logic block gates with the registered CondEx. It also keeps a retired-instruction counter and flags undefined opcodes.

Parameters:
CNT_W, 32, width of retired-instruction counter instr_count

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high; state->FETCH, counter->0 on the rising edge
Op  in  2  instruction bits [27:26]
Funct  in  6  instruction bits [25:20]; [5]=I (immediate), [0]=L (load)/S
mem_ready  in  1  memory handshake; port exists only with CTRL_MEM_WAIT_EN
IRWrite  out  1  instruction register load
NextPC  out  1  unconditional PC write (fetch)
RegW  out  1  register write request (gated later by CondEx)
MemW  out  1  memory write request (gated later by CondEx)
Branch  out  1  branch request (becomes PCS path)
AdrSrc  out  1  0=PC, 1=ALU result as memory address
ALUSrcA  out  2  00=RD1, 01=PC, 10=ALUResult
ALUSrcB  out  2  00=RD2/ExtImm path reg, 01=ExtImm, 10=constant 4
ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult
ALUOp  out  1  1=ALU decoder uses Funct, 0=ADD
illegal  out  1  one-cycle pulse in UNKNOWN state
instr_count  out  CNT_W  retired instructions

Behaviour:
- Moore machine. Outputs are pure decode of the state register. Only the next state depends on Op/Funct.
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTER, EXECUTEI, ALUWB, BRANCH, UNKNOWN. Encoding is 4-bit.
- Transitions:
  - FETCH->DECODE.
  - DECODE: Op=00 & Funct[5]=0 -> EXECUTER. Op=00 & Funct[5]=1 -> EXECUTEI. Op=01 -> MEMADR. Op=10 -> BRANCH. Op=11 -> UNKNOWN.
  - MEMADR: Funct[0]=1 -> MEMRD, else MEMWR.
  - MEMRD->MEMWB.
  - EXECUTER/EXECUTEI->ALUWB.
  - MEMWB, MEMWR, ALUWB, BRANCH, UNKNOWN -> FETCH.
- Output decode (unlisted outputs are 0):
  - FETCH: IRWrite=1, NextPC=1, AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ResultSrc=10, ALUOp=0.
  - DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10.
  - MEMADR: ALUSrcA=00, ALUSrcB=01, ALUOp=0.
  - MEMRD: AdrSrc=1, ResultSrc=00.
  - MEMWB: ResultSrc=01, RegW=1.
  - MEMWR: AdrSrc=1, ResultSrc=00, MemW=1.
  - EXECUTER: ALUSrcA=00, ALUSrcB=00, ALUOp=1.
  - EXECUTEI: ALUSrcA=00, ALUSrcB=01, ALUOp=1.
  - ALUWB: ResultSrc=00, RegW=1.
  - BRANCH: ALUSrcA=10, ALUSrcB=01, ResultSrc=10, Branch=1, ALUOp=0.
  - UNKNOWN: illegal=1, all strobes 0.
- Latency: data-processing and STR take 4 cycles, LDR 5, B 3, undefined opcode 3.
- RegW/MemW/Branch are asserted exactly one cycle after DECODE-or-later evaluation. This matches the downstream one-cycle CondEx register.
- instr_count increments by 1 on the edge leaving MEMWB, MEMWR, ALUWB or BRANCH. It does not increment for UNKNOWN. It wraps modulo 2^CNT_W.
- Reset has priority over everything, including mid-instruction (e.g. during MEMRD). On the next edge the state is FETCH and instr_count is 0. While in reset the outputs therefore show the FETCH decode after the first edge.
- Unreachable state codes decode all outputs to 0 and go to FETCH.

Optional Feature:
CTRL_MEM_WAIT_EN
- Defined: the mem_ready port exists.
  - FETCH, MEMRD and MEMWR hold while mem_ready=0.
  - IRWrite and NextPC in FETCH, and MemW in MEMWR, are ANDed with mem_ready, so each fires exactly once per access.
  - The transition out of the state occurs only on an edge with mem_ready=1.
- Undefined: the port is absent and memory is treated as always ready, which is identical to mem_ready tied to 1.

Decomposition:
- Shared header ctrl_defs.vh holds the state-code localparams, the ALUSrcA/ALUSrcB/ResultSrc select codes and the Op codes (OP_DP=00, OP_MEM=01, OP_B=10).
- One natural sub-module, ctrl_out_decode: purely combinational, mapping state (and mem_ready when enabled) to the control word.
- The state register, next-state logic and counter stay in the top module.

Test Plan:
- Reset, then Op=00 Funct=000100 (ADD reg) -> FETCH,DECODE,EXECUTER,ALUWB,FETCH; RegW=1 only in ALUWB; instr_count 0->1.
- Op=01 Funct=011001 (LDR) -> MEMADR, MEMRD (AdrSrc=1), MEMWB (ResultSrc=01, RegW=1); 5 cycles; count +1.
- Op=01 Funct=011000 (STR) -> MEMWR with MemW=1, AdrSrc=1 for one cycle; back to FETCH after 4 cycles.
- Op=10 -> BRANCH with Branch=1, ALUSrcA=10, ALUSrcB=01 for one cycle; Op=11 -> illegal=1 for one cycle, count unchanged.
- Reset asserted while in MEMRD -> next edge state=FETCH, IRWrite=1, instr_count=0, no MemW/RegW pulse.
- With CTRL_MEM_WAIT_EN: mem_ready=0 for 3 cycles in FETCH -> state holds and IRWrite=0. Then mem_ready=1 -> IRWrite=NextPC=1 for exactly one cycle, then DECODE.
